// File: rtl/dual_port_ram.sv
// dual_port_ram: true dual-port synchronous RAM with registered, read-first outputs
//
// Ports:
//   clk             rising-edge clock for all state
//   rst             synchronous active-high reset; clears both outputs and suppresses writes
//   address_a/b     word address of port A/B
//   data_in_a/b     write data of port A/B
//   write_enable_a/b 1 = write, 0 = read (the port reads the old word either way)
//   data_out_a/b    registered read data, one cycle latency
//
// Optional feature: define DPRAM_CLEAR_ON_RESET_EN to also zero every word on a reset edge.
// Leaving it undefined keeps mem free of reset logic so it can map to block RAM.
module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0] data_in_a,
    input  logic                  write_enable_a,
    output logic [DATA_WIDTH-1:0] data_out_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] data_in_b,
    input  logic                  write_enable_b,
    output logic [DATA_WIDTH-1:0] data_out_b
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_a <= '0;
            data_out_b <= '0;
`ifdef DPRAM_CLEAR_ON_RESET_EN
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`endif
        end else begin
            data_out_a <= mem[address_a];
            data_out_b <= mem[address_b];
            // Port A's write is issued last so it wins a same-address collision.
            if (write_enable_b) mem[address_b] <= data_in_b;
            if (write_enable_a) mem[address_a] <= data_in_a;
        end
    end
endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: directed and randomized checks of dual_port_ram against an array model
module tb_dual_port_ram;
    logic       clk = 0;
    logic       rst = 1;
    logic [3:0] address_a = '0, address_b = '0;
    logic [7:0] data_in_a = '0, data_in_b = '0;
    logic       write_enable_a = 0, write_enable_b = 0;
    logic [7:0] data_out_a, data_out_b;

    dual_port_ram dut (
        .clk(clk), .rst(rst),
        .address_a(address_a), .data_in_a(data_in_a), .write_enable_a(write_enable_a), .data_out_a(data_out_a),
        .address_b(address_b), .data_in_b(data_in_b), .write_enable_b(write_enable_b), .data_out_b(data_out_b)
    );

    always #5 clk = ~clk;

    logic [7:0] m [16];
    bit         kn [16];
    logic [7:0] ea, eb;
    bit         ka, kb;
    int         errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict outputs from the memory model, compare after the edge.
    task automatic cyc(input bit r, input bit wa, input logic [3:0] aa, input logic [7:0] da,
                       input bit wb, input logic [3:0] ab, input logic [7:0] db);
        rst = r; write_enable_a = wa; address_a = aa; data_in_a = da;
        write_enable_b = wb; address_b = ab; data_in_b = db;
        if (r) begin
            ea = 8'h00; eb = 8'h00; ka = 1; kb = 1;
`ifdef DPRAM_CLEAR_ON_RESET_EN
            for (int i = 0; i < 16; i++) begin m[i] = 8'h00; kn[i] = 1; end
`endif
        end else begin
            ea = m[aa]; ka = kn[aa];
            eb = m[ab]; kb = kn[ab];
            if (wa) begin m[aa] = da; kn[aa] = 1; end
            if (wb && !(wa && aa == ab)) begin m[ab] = db; kn[ab] = 1; end
        end
        @(posedge clk);
        #1;
        if (ka) chk("model_a", data_out_a, ea);
        if (kb) chk("model_b", data_out_b, eb);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) kn[i] = 0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("reset_a", data_out_a, 8'h00);
        chk("reset_b", data_out_b, 8'h00);
`ifdef DPRAM_CLEAR_ON_RESET_EN
        cyc(0, 0, 4'h5, 0, 0, 4'h5, 0);
        chk("clear_a5", data_out_a, 8'h00);
`endif
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 4'(2 * i), 8'($urandom), 1, 4'(2 * i + 1), 8'($urandom));

        cyc(0, 1, 4'h2, 8'hAA, 1, 4'h3, 8'h55);
        cyc(0, 0, 4'h2, 0, 0, 4'h3, 0);
        chk("indep_a", data_out_a, 8'hAA);
        chk("indep_b", data_out_b, 8'h55);

        cyc(0, 1, 4'h7, 8'h5A, 0, 4'h0, 0);
        cyc(0, 1, 4'h7, 8'h3C, 0, 4'h7, 0);
        chk("cross_old_b", data_out_b, 8'h5A);
        cyc(0, 0, 4'h0, 0, 0, 4'h7, 0);
        chk("cross_new_b", data_out_b, 8'h3C);

        cyc(0, 1, 4'h4, 8'h11, 0, 4'h0, 0);
        cyc(0, 1, 4'h4, 8'h22, 0, 4'h0, 0);
        chk("rdfirst_old_a", data_out_a, 8'h11);
        cyc(0, 0, 4'h4, 0, 0, 4'h0, 0);
        chk("rdfirst_new_a", data_out_a, 8'h22);

        cyc(0, 1, 4'h9, 8'hF0, 1, 4'h9, 8'h0F);
        cyc(0, 0, 4'h9, 0, 0, 4'h9, 0);
        chk("collide_a", data_out_a, 8'hF0);
        chk("collide_b", data_out_b, 8'hF0);

        cyc(0, 1, 4'h1, 8'h12, 0, 4'h0, 0);
        cyc(1, 1, 4'h1, 8'h77, 0, 4'h0, 0);
        chk("rstmid_a", data_out_a, 8'h00);
        chk("rstmid_b", data_out_b, 8'h00);
        cyc(0, 0, 4'h1, 0, 0, 4'h1, 0);
`ifdef DPRAM_CLEAR_ON_RESET_EN
        chk("rstmid_rd", data_out_a, 8'h00);
`else
        chk("rstmid_rd", data_out_a, 8'h12);
`endif
        checks++;
        assert (data_out_b !== 8'h77) else begin
            errors++;
            $error("FAIL rstmid_nowrite observed=%h expected=not 77", data_out_b);
        end

        for (int n = 0; n < 300; n++)
            cyc($urandom_range(31) == 0, 1'($urandom), 4'($urandom), 8'($urandom),
                1'($urandom), 4'($urandom), 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
